// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive front end.
// Also holds the single-bit NRZI decode used by the deserialiser.
package usb_rx_pkg;

   localparam int   USB_STUFF_LEN = 6;
   localparam logic USB_J_LEVEL   = 1'b1;
   localparam int   USB_BYTE_W    = 8;

   // Per-strobe decision from the unstuffer: at most one field is set.
   typedef struct packed {
      logic accept;
      logic stuff;
      logic err;
   } unstuff_dec_t;

   // NRZI: no transition on the line means a 1, a transition means a 0.
   function automatic logic nrzi_decode(input logic level, input logic prev_level);
      return (level == prev_level);
   endfunction

endpackage

// File: rtl/bit_unstuffer.sv
// Tracks the run of decoded 1s and decides whether each strobed bit is data,
// a correctly stuffed 0, or a bit-stuff violation.
module bit_unstuffer
   import usb_rx_pkg::*;
#(
   parameter int STUFF_LEN = USB_STUFF_LEN,
   localparam int CNT_W = $clog2(STUFF_LEN + 1)
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         clear,
   input  logic         shift_enable,
   input  logic         bit_in,
   output unstuff_dec_t dec
);

   logic [CNT_W-1:0] ones_cnt_reg;
   logic [CNT_W-1:0] ones_cnt_next;
   logic             at_stuff;

   assign at_stuff = (ones_cnt_reg == CNT_W'(STUFF_LEN));

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ones_cnt_reg <= '0;
      end else begin
         ones_cnt_reg <= ones_cnt_next;
      end
   end

   // The run counter ignores word boundaries; only clear or a 0 restarts it.
   always_comb begin
      dec           = '0;
      ones_cnt_next = ones_cnt_reg;
      if (clear) begin
         ones_cnt_next = '0;
      end else if (shift_enable) begin
         if (at_stuff) begin
            ones_cnt_next = '0;
            dec.stuff     = ~bit_in;
            dec.err       = bit_in;
         end else if (bit_in) begin
            ones_cnt_next = ones_cnt_reg + CNT_W'(1);
            dec.accept    = 1'b1;
         end else begin
            ones_cnt_next = '0;
            dec.accept    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/nrzi_unstuff_deser.sv
// USB receive front end: NRZI decode, bit unstuffing and LSB-first
// word assembly with registered, single-cycle status pulses.
module nrzi_unstuff_deser
   import usb_rx_pkg::*;
#(
   parameter int   DATA_WIDTH = USB_BYTE_W,
   parameter int   STUFF_LEN  = USB_STUFF_LEN,
   parameter logic IDLE_LEVEL = USB_J_LEVEL
) (
   input  logic                  clk,
   input  logic                  n_rst,
   input  logic                  d_plus_sync,
   input  logic                  shift_enable,
   input  logic                  clear,
   output logic                  d_orig,
   output logic [DATA_WIDTH-1:0] rcv_word,
   output logic                  word_ready,
   output logic                  stuff_bit,
   output logic                  stuff_err
);

   localparam int BIT_W = $clog2(DATA_WIDTH);

   logic                  prev_level_reg, prev_level_next;
   logic                  d_orig_reg, d_orig_next;
   logic [DATA_WIDTH-1:0] shreg_reg, shreg_next;
   logic [BIT_W-1:0]      bit_cnt_reg, bit_cnt_next;
   logic [DATA_WIDTH-1:0] rcv_word_reg, rcv_word_next;
   logic                  word_ready_reg, word_ready_next;
   logic                  stuff_bit_reg, stuff_bit_next;
   logic                  stuff_err_reg, stuff_err_next;

   logic                  dec_bit;
   logic [DATA_WIDTH-1:0] shreg_shifted;
   unstuff_dec_t          dec;

   assign dec_bit = nrzi_decode(d_plus_sync, prev_level_reg);

   // New bit enters at the MSB so the first bit received ends up at bit 0.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH - 1; gi++) begin : g_shift
         assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
   endgenerate
   assign shreg_shifted[DATA_WIDTH-1] = dec_bit;

   bit_unstuffer #(
      .STUFF_LEN(STUFF_LEN)
   ) u_unstuffer (
      .clk         (clk),
      .n_rst       (n_rst),
      .clear       (clear),
      .shift_enable(shift_enable),
      .bit_in      (dec_bit),
      .dec         (dec)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         prev_level_reg <= IDLE_LEVEL;
         d_orig_reg     <= 1'b1;
         shreg_reg      <= '0;
         bit_cnt_reg    <= '0;
         rcv_word_reg   <= '0;
         word_ready_reg <= 1'b0;
         stuff_bit_reg  <= 1'b0;
         stuff_err_reg  <= 1'b0;
      end else begin
         prev_level_reg <= prev_level_next;
         d_orig_reg     <= d_orig_next;
         shreg_reg      <= shreg_next;
         bit_cnt_reg    <= bit_cnt_next;
         rcv_word_reg   <= rcv_word_next;
         word_ready_reg <= word_ready_next;
         stuff_bit_reg  <= stuff_bit_next;
         stuff_err_reg  <= stuff_err_next;
      end
   end

   // Stuff pulses come straight from the unstuffer, which is silent on clear.
   always_comb begin
      prev_level_next = prev_level_reg;
      d_orig_next     = d_orig_reg;
      shreg_next      = shreg_reg;
      bit_cnt_next    = bit_cnt_reg;
      rcv_word_next   = rcv_word_reg;
      word_ready_next = 1'b0;
      stuff_bit_next  = dec.stuff;
      stuff_err_next  = dec.err;
      if (clear) begin
         prev_level_next = IDLE_LEVEL;
         d_orig_next     = 1'b1;
         shreg_next      = '0;
         bit_cnt_next    = '0;
      end else if (shift_enable) begin
         prev_level_next = d_plus_sync;
         d_orig_next     = dec_bit;
         if (dec.accept) begin
            shreg_next = shreg_shifted;
            if (bit_cnt_reg == BIT_W'(DATA_WIDTH - 1)) begin
               bit_cnt_next    = '0;
               rcv_word_next   = shreg_shifted;
               word_ready_next = 1'b1;
            end else begin
               bit_cnt_next = bit_cnt_reg + BIT_W'(1);
            end
         end
      end
   end

   assign d_orig     = d_orig_reg;
   assign rcv_word   = rcv_word_reg;
   assign word_ready = word_ready_reg;
   assign stuff_bit  = stuff_bit_reg;
   assign stuff_err  = stuff_err_reg;

endmodule

// File: doc/nrzi_unstuff_deser.md
# nrzi_unstuff_deser

Parametrised USB receive front end: NRZI-decodes the synchronised D+ line on each `shift_enable` strobe, removes stuffed bits, flags bit-stuff violations, and assembles the accepted bits LSB-first into `DATA_WIDTH`-bit words with a one-cycle ready pulse. It replaces the bare single-bit NRZI decoder. It sits between the edge-detect/timer logic that produces `shift_enable` and the receive control FSM and FIFO.

## Interface
Parameters:
- `DATA_WIDTH`, default 8: width of the assembled word; must be at least 2.
- `STUFF_LEN`, default 6: number of consecutive decoded 1s after which a stuffed 0 is expected; must be at least 1.
- `IDLE_LEVEL`, default 1'b1: D+ line level at idle (J). Used to load the previous-level register.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state updates occur on its rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `d_plus_sync`  in  1  synchronised D+ level.
- `shift_enable`  in  1  one-cycle strobe marking the bit-sample point.
- `clear`  in  1  synchronous restart, used at packet start or EOP; has priority over `shift_enable`.
- `d_orig`  out  1  registered value of the most recent decoded bit, stuffed bits included.
- `rcv_word`  out  DATA_WIDTH  most recently completed word; held until the next word completes.
- `word_ready`  out  1  one-cycle pulse when `rcv_word` updates.
- `stuff_bit`  out  1  one-cycle pulse when a correct stuffed 0 is discarded.
- `stuff_err`  out  1  one-cycle pulse when a 1 arrives in the stuff position.

## Operation
- Decoding, on a `shift_enable` cycle: b = 1 if `d_plus_sync` == `prev_level`, otherwise b = 0. Then `prev_level` <= `d_plus_sync` and `d_orig` <= b.
- Unstuffing, evaluated on the same cycle with `ones_cnt` (width clog2(STUFF_LEN+1)):
  - If `ones_cnt` == STUFF_LEN: the bit is not accepted, `ones_cnt` <= 0, and one pulse is raised: `stuff_bit` if b=0, `stuff_err` if b=1.
  - Otherwise, if b=1: `ones_cnt` += 1 and the bit is accepted.
  - Otherwise (b=0): `ones_cnt` <= 0 and the bit is accepted.
- Deserialising: each accepted bit shifts in at the MSB, `shreg` <= {b, shreg[DATA_WIDTH-1:1]}, and `bit_cnt` increments. When the accepted bit is bit DATA_WIDTH-1:
  - `rcv_word` <= {b, shreg[DATA_WIDTH-1:1]};
  - `word_ready` pulses;
  - `bit_cnt` wraps to 0.
- `ones_cnt` runs continuously across word boundaries; stuffing is not word-aligned.
- `clear` sets `prev_level` to IDLE_LEVEL and `d_orig` to 1, and zeroes `ones_cnt`, `bit_cnt` and `shreg`. No pulse is raised in that cycle. `rcv_word` keeps its value.
- After `stuff_err` the block keeps decoding. Discarding the packet is the controller's decision.

## Timing
- Reset values:
  - `prev_level` = IDLE_LEVEL and `d_orig` = 1;
  - `rcv_word` = 0;
  - `word_ready`, `stuff_bit`, `stuff_err` = 0;
  - all counters and `shreg` = 0.
- All outputs are registered. `d_orig`, `word_ready`, `stuff_bit` and `stuff_err` become visible in the cycle after the `shift_enable` cycle that produced them.
- Each pulse is exactly one cycle wide. `word_ready` and `stuff_bit`/`stuff_err` are mutually exclusive, because a stuffed bit is never accepted.
- Without `shift_enable`, all state holds and all pulses deassert.
- `clear` together with `shift_enable`: `clear` wins and the sample is dropped.
- Reset mid-word: the partial word is lost and `rcv_word` returns to 0.
- Back-to-back `shift_enable` (every cycle) must be supported with no throughput loss.

## Structure
- Shared package `usb_rx_pkg` holds:
  - `USB_STUFF_LEN` = 6;
  - `USB_J_LEVEL` = 1'b1;
  - `USB_BYTE_W` = 8.
- One sub-module, `bit_unstuffer`, holds `ones_cnt` and produces the accept, stuff and error decisions from b and `shift_enable`.
- The top level holds the NRZI register, the deserialiser and the output registers.

## Test plan
All bit sequences below are decoded values; the bench NRZI-encodes them onto `d_plus_sync`.
- Reset with D+ = 1 → `d_orig`=1, `rcv_word`=0x00, and no pulses for 3 idle cycles.
- Decoded 1,0,1,0,0,1,0,1 on 8 consecutive strobes → `word_ready` on the cycle after strobe 8, with `rcv_word`=0xA5.
- Decoded 1×6, 0, 1, 1 → `stuff_bit` pulse after strobe 7, then `word_ready` after strobe 9 with `rcv_word`=0xFF.
- Decoded 1×7 → `stuff_err` pulse after strobe 7, no `word_ready`, and `ones_cnt` = 0 afterwards.
- Three bits sent, then `clear` asserted together with a strobe, then decoded 0x3C LSB-first → `word_ready` after the 8th post-clear strobe with `rcv_word`=0x3C.
- Instance with DATA_WIDTH=16, STUFF_LEN=3 sending 0xF00F → one stuff pulse after each run of three 1s, and `rcv_word`=0xF00F after the 16th accepted bit.
